rr_arbiter_8: RTL and testbench

Round-robin arbiter that shares one downstream resource, such as a shared encoder or bus slot, among 8 requesters. It issues a registered one-hot grant and a 3-bit grant index. A holder keeps its grant while its request stays high, up to a configurable tenure limit. Selection rotates so that no requester starves. It sits between the request sources and the shared datapath and drives that datapath's select and enable lines.

---
 rtl/arb_pkg.sv | 13 +
 rtl/rr_arbiter_8_if.sv | 29 ++
 rtl/prio_enc_8x3.sv | 26 ++
 rtl/rr_arbiter_8.sv | 126 ++++++++++++
 tb/tb_rr_arbiter_8.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared constants and types for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int NREQ  = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface rr_arbiter_8_if;
  import arb_pkg::*;

  logic             en;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;

  // Requester side: drives requests, observes the grant.
  modport master (
    output en,
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid
  );

  // Arbiter side: consumes requests, drives the grant.
  modport slave (
    input  en,
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_valid
  );

endinterface

// File: rtl/prio_enc_8x3.sv
// Rotating priority encoder: first set bit of vec searching from start upward, modulo 8.
module prio_enc_8x3
  import arb_pkg::*;
(
  input  logic [NREQ-1:0]  vec,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    logic [IDX_W-1:0] pos;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = start + IDX_W'(k);
      if (vec[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with registered one-hot grant and tenure limit.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter_8_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam bit               LIMITED  = (MAX_HOLD != 0);

  arb_state_t       state,      nxt_state;
  logic [IDX_W-1:0] ptr,        nxt_ptr;
  logic [CNT_W-1:0] hold_cnt,   nxt_cnt;
  logic [IDX_W-1:0] gnt_idx_p0, nxt_idx;
  logic             vld_p0,     nxt_vld;
  logic [NREQ-1:0]  gnt_p0;

  logic [NREQ-1:0]  holder_mask;
  logic [NREQ-1:0]  req_masked;
  logic [IDX_W-1:0] next_start;
  logic [IDX_W-1:0] idx_norm, idx_mask;
  logic             found_norm, found_mask;
  logic             holder_req, expired;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign holder_mask = NREQ'(1) << gnt_idx_p0;
  assign req_masked  = bus.req & ~holder_mask;
  assign next_start  = gnt_idx_p0 + IDX_W'(1);
  assign holder_req  = bus.req[gnt_idx_p0];
  assign expired     = LIMITED && (hold_cnt == HOLD_LIM);

  // Idle search honours the stored pointer.
  prio_enc_8x3 u_enc_norm (
    .vec   (bus.req),
    .start (ptr),
    .idx   (idx_norm),
    .found (found_norm)
  );

  // Handover search starts just past the holder and excludes it.
  prio_enc_8x3 u_enc_mask (
    .vec   (req_masked),
    .start (next_start),
    .idx   (idx_mask),
    .found (found_mask)
  );

  // Next-state: grant from idle, extend tenure, release or time out.
  always_comb begin
    nxt_state = state;
    nxt_ptr   = ptr;
    nxt_cnt   = hold_cnt;
    nxt_idx   = gnt_idx_p0;
    nxt_vld   = vld_p0;
    case (state)
      IDLE: begin
        if (bus.en && found_norm) begin
          nxt_state = GRANT;
          nxt_idx   = idx_norm;
          nxt_vld   = 1'b1;
          nxt_cnt   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (!holder_req) begin
          nxt_ptr = next_start;
          if (bus.en && found_mask) begin
            nxt_idx = idx_mask;
            nxt_cnt = CNT_W'(1);
          end else begin
            nxt_state = IDLE;
            nxt_idx   = '0;
            nxt_vld   = 1'b0;
            nxt_cnt   = '0;
          end
        end else if (expired) begin
          // Lone holder (or en low) is simply re-granted with a fresh tenure.
          nxt_ptr = next_start;
          nxt_cnt = CNT_W'(1);
          if (bus.en && found_mask) begin
            nxt_idx = idx_mask;
          end
        end else begin
          nxt_cnt = sat_inc(hold_cnt);
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_idx   = '0;
        nxt_vld   = 1'b0;
        nxt_cnt   = '0;
      end
    endcase
  end

  // State, pointer, tenure counter and registered grant outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      hold_cnt   <= '0;
      gnt_idx_p0 <= '0;
      vld_p0     <= 1'b0;
      gnt_p0     <= '0;
    end else begin
      state      <= nxt_state;
      ptr        <= nxt_ptr;
      hold_cnt   <= nxt_cnt;
      gnt_idx_p0 <= nxt_idx;
      vld_p0     <= nxt_vld;
      gnt_p0     <= nxt_vld ? (NREQ'(1) << nxt_idx) : '0;
    end
  end

  assign bus.gnt       = gnt_p0;
  assign bus.gnt_idx   = gnt_idx_p0;
  assign bus.gnt_valid = vld_p0;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8: default, MAX_HOLD=2 and MAX_HOLD=3 instances.
module tb_rr_arbiter_8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rr_arbiter_8_if ifd ();
  rr_arbiter_8_if if2 ();
  rr_arbiter_8_if if3 ();

  rr_arbiter_8 dutd (.clk(clk), .rst_n(rst_n), .bus(ifd.slave));
  rr_arbiter_8 #(.MAX_HOLD(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  rr_arbiter_8 #(.MAX_HOLD(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    int         which;
    logic       vld;
    logic [2:0] idx;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int which, input logic v, input logic [2:0] i);
    exp_t e;
    e.tag = tag; e.which = which; e.vld = v; e.idx = i;
    sb.push_back(e);
  endtask

  // Advance one edge, then retire every pending expectation against its instance.
  task automatic edge_check();
    exp_t e;
    logic [7:0] g, eg;
    logic [2:0] ix;
    logic       v;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: observed empty queue expected an entry");
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.which)
        2:       begin g = if2.gnt; ix = if2.gnt_idx; v = if2.gnt_valid; end
        3:       begin g = if3.gnt; ix = if3.gnt_idx; v = if3.gnt_valid; end
        default: begin g = ifd.gnt; ix = ifd.gnt_idx; v = ifd.gnt_valid; end
      endcase
      eg = e.vld ? (8'd1 << e.idx) : 8'd0;
      chk({e.tag, "_gnt"}, g, eg);
      chk({e.tag, "_idx"}, {5'd0, ix}, e.vld ? {5'd0, e.idx} : 8'd0);
      chk({e.tag, "_vld"}, {7'd0, v}, {7'd0, e.vld});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ifd.en = 1'b0; ifd.req = 8'h00;
    if2.en = 1'b0; if2.req = 8'h00;
    if3.en = 1'b0; if3.req = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", ifd.gnt, 8'h00);
    chk("rst_idx", {5'd0, ifd.gnt_idx}, 8'h00);
    chk("rst_vld", {7'd0, ifd.gnt_valid}, 8'h00);
    chk("rst_ptr", {5'd0, dutd.ptr}, 8'h00);
    rst_n = 1'b1;

    // en low blocks grants from idle
    ifd.en = 1'b0; ifd.req = 8'h81;
    push("en_off0", 0, 1'b0, 3'd0); edge_check();
    push("en_off1", 0, 1'b0, 3'd0); edge_check();
    ifd.en = 1'b1;
    push("en_on", 0, 1'b1, 3'd0); edge_check();
    ifd.req = 8'h80;
    push("rel_to7", 0, 1'b1, 3'd7); edge_check();
    chk("rel_to7_ptr", {5'd0, dutd.ptr}, 8'd1);

    // asynchronous reset in the middle of a tenure
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt", ifd.gnt, 8'h00);
    chk("arst_idx", {5'd0, ifd.gnt_idx}, 8'h00);
    chk("arst_vld", {7'd0, ifd.gnt_valid}, 8'h00);
    chk("arst_ptr", {5'd0, dutd.ptr}, 8'h00);
    chk("arst_cnt", dutd.hold_cnt, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    ifd.req = 8'h81;
    push("post_rst", 0, 1'b1, 3'd0); edge_check();
    ifd.req = 8'h00;
    push("idle0", 0, 1'b0, 3'd0); edge_check();

    // release handover 5 -> 1 with no idle cycle
    ifd.req = 8'h20;
    push("h5a", 0, 1'b1, 3'd5); edge_check();
    ifd.req = 8'h22;
    push("h5b", 0, 1'b1, 3'd5); edge_check();
    ifd.req = 8'h02;
    push("hand1", 0, 1'b1, 3'd1); edge_check();
    chk("hand1_ptr", {5'd0, dutd.ptr}, 8'd6);

    // en low keeps tenure, release then goes idle
    ifd.en = 1'b0; ifd.req = 8'h03;
    push("enoff_keep", 0, 1'b1, 3'd1); edge_check();
    ifd.req = 8'h01;
    push("enoff_rel", 0, 1'b0, 3'd0); edge_check();
    chk("enoff_ptr", {5'd0, dutd.ptr}, 8'd2);
    ifd.en = 1'b1;
    push("enon_wrap", 0, 1'b1, 3'd0); edge_check();
    ifd.req = 8'h00;
    push("idle1", 0, 1'b0, 3'd0); edge_check();

    // rotation fairness, two cycles per tenure
    if2.en = 1'b1; if2.req = 8'hFF;
    for (int k = 0; k < 18; k++) begin
      push("rot", 2, 1'b1, 3'((k / 2) % 8));
      edge_check();
    end
    if2.req = 8'h00;

    // lone requester re-granted on timeout
    if3.en = 1'b1; if3.req = 8'h10;
    for (int k = 0; k < 6; k++) begin
      push("lone", 3, 1'b1, 3'd4);
      edge_check();
      chk("lone_cnt", dut3.hold_cnt, 8'((k % 3) + 1));
    end
    if3.req = 8'h00;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
